// File: rtl/core_pkg.sv
// Shared encodings for the RV32 core pipeline.
// Load/store sizes, writeback source selects and MEM stage FSM states.
package core_pkg;

    localparam logic [3:0] SIZE_BYTE = 4'b0001;
    localparam logic [3:0] SIZE_HALF = 4'b0011;
    localparam logic [3:0] SIZE_WORD = 4'b1111;

    localparam logic [2:0] SRC_ALU       = 3'd0;
    localparam logic [2:0] SRC_DMEM      = 3'd1;
    localparam logic [2:0] SRC_PC_PLUS_4 = 3'd2;
    localparam logic [2:0] SRC_IMM       = 3'd3;
    localparam logic [2:0] SRC_MUL       = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/core_mem_align.sv
// Byte-enable, store-data replication and alignment check for data accesses.
// Unknown size encodings fall through to word.
module core_mem_align
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      addr_i,
    input  logic [3:0]      d_size_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misaligned_o
);

    logic is_byte;
    logic is_half;

    assign is_byte = (d_size_i == SIZE_BYTE);
    assign is_half = (d_size_i == SIZE_HALF);

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = rs2_i;
        misaligned_o = (addr_i != 2'b00);
        unique case (1'b1)
            is_byte: begin
                be_o         = 4'b0001 << addr_i;
                wdata_o      = {(XLEN/8){rs2_i[7:0]}};
                misaligned_o = 1'b0;
            end
            is_half: begin
                be_o         = 4'b0011 << addr_i;
                wdata_o      = {(XLEN/16){rs2_i[15:0]}};
                misaligned_o = addr_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_mem_stage.sv
// RV32 memory stage: req/gnt/rvalid data bus master and MEM/WB register.
// Optional CORE_MEM_BUS_ERR_EN adds data_err_i / bus_err_o.
module core_mem_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned FLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [3:0]      d_size_i,
    input  logic            d_unsigned_i,
    input  logic [2:0]      mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_plus_4_i,
    input  logic [XLEN-1:0] mul_result_i,
    output logic            stall_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i,
`ifdef CORE_MEM_BUS_ERR_EN
    input  logic            data_err_i,
    output logic            bus_err_o,
`endif
    output logic            misalign_o,
    output logic            wb_valid_o,
    output logic [3:0]      wb_d_size_o,
    output logic            wb_d_unsigned_o,
    output logic [2:0]      wb_mem_to_reg_o,
    output logic            wb_reg_write_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_alu_result_o,
    output logic [XLEN-1:0] wb_imm_o,
    output logic [XLEN-1:0] wb_pc_plus_4_o,
    output logic [XLEN-1:0] wb_mul_result_o,
    output logic [XLEN-1:0] wb_data_rd_data_o
);

    // FLEN only keeps the parameter list uniform across stages.
    if (FLEN == 0) begin : g_flen_chk
        $error("core_mem_stage: FLEN must be non-zero");
    end

    typedef struct packed {
        logic [3:0]      d_size;
        logic            d_unsigned;
        logic [2:0]      mem_to_reg;
        logic            reg_write;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] mul_result;
    } mem_wb_t;

    mem_state_e      state_q, state_d;
    mem_wb_t         pend_q, pend_d;
    mem_wb_t         wb_q, wb_d;
    mem_wb_t         ex_pl;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misalign_q, misalign_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            misaligned;
    logic            is_mem;
    logic            done;
    logic            resp_err;

    core_mem_align #(
        .XLEN(XLEN)
    ) u_align (
        .addr_i      (alu_result_i[1:0]),
        .d_size_i    (d_size_i),
        .rs2_i       (rs2_data_i),
        .be_o        (be),
        .wdata_o     (wdata),
        .misaligned_o(misaligned)
    );

    assign ex_pl = '{
        d_size:     d_size_i,
        d_unsigned: d_unsigned_i,
        mem_to_reg: mem_to_reg_i,
        reg_write:  reg_write_i,
        rd_addr:    rd_addr_i,
        alu_result: alu_result_i,
        imm:        imm_i,
        pc_plus_4:  pc_plus_4_i,
        mul_result: mul_result_i
    };

    assign is_mem = mem_read_i | mem_write_i;

    // A response completes either together with its grant or later in WAIT.
    assign done = ((state_q == REQ) & data_gnt_i & data_rvalid_i)
                | ((state_q == WAIT) & data_rvalid_i);

`ifdef CORE_MEM_BUS_ERR_EN
    logic bus_err_q, bus_err_d;

    assign resp_err  = data_err_i;
    assign bus_err_d = done & data_err_i;
    assign bus_err_o = bus_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        wb_d       = wb_q;
        wb_valid_d = 1'b0;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (!is_mem) begin
                        wb_d       = ex_pl;
                        wb_valid_d = 1'b1;
                    end else if (misaligned) begin
                        wb_d           = ex_pl;
                        wb_d.reg_write = 1'b0;
                        wb_valid_d     = 1'b1;
                        misalign_d     = 1'b1;
                    end else begin
                        pend_d  = ex_pl;
                        req_d   = 1'b1;
                        we_d    = mem_write_i;
                        be_d    = be;
                        addr_d  = {alu_result_i[XLEN-1:2], 2'b00};
                        wdata_d = wdata;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    req_d = 1'b0;
                    if (!data_rvalid_i) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: ;
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d    = IDLE;
            wb_d       = pend_q;
            wb_valid_d = 1'b1;
            rdata_d    = data_rdata_i;
            if (resp_err) begin
                wb_d.reg_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            wb_q       <= wb_d;
            wb_valid_q <= wb_valid_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign stall_o           = (state_q != IDLE);
    assign data_req_o        = req_q;
    assign data_we_o         = we_q;
    assign data_be_o         = be_q;
    assign data_addr_o       = addr_q;
    assign data_wdata_o      = wdata_q;
    assign misalign_o        = misalign_q;
    assign wb_valid_o        = wb_valid_q;
    assign wb_d_size_o       = wb_q.d_size;
    assign wb_d_unsigned_o   = wb_q.d_unsigned;
    assign wb_mem_to_reg_o   = wb_q.mem_to_reg;
    assign wb_reg_write_o    = wb_q.reg_write;
    assign wb_rd_addr_o      = wb_q.rd_addr;
    assign wb_alu_result_o   = wb_q.alu_result;
    assign wb_imm_o          = wb_q.imm;
    assign wb_pc_plus_4_o    = wb_q.pc_plus_4;
    assign wb_mul_result_o   = wb_q.mul_result;
    assign wb_data_rd_data_o = rdata_q;

endmodule

// File: tb/tb_core_mem_stage.sv
// Self-checking bench for core_mem_stage: vector table, directed
// corner sequences and a randomized transaction-level reference model.
module tb_core_mem_stage;

    typedef struct packed {
        logic [3:0]  sz;
        logic        uns;
        logic [2:0]  m2r;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [31:0] mul;
    } pl_t;

    typedef struct {
        logic [3:0]  sz;
        logic [1:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [3:0]  d_size = '0;
    logic        d_uns = 1'b0;
    logic [2:0]  m2r = '0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] alu = '0, rs2 = '0, imm = '0, pc4 = '0, mul = '0;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        stall_o, data_req_o, data_we_o, misalign_o, wb_valid_o;
    logic [3:0]  data_be_o, wb_d_size_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        wb_d_unsigned_o, wb_reg_write_o;
    logic [2:0]  wb_mem_to_reg_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_alu_result_o, wb_imm_o, wb_pc_plus_4_o;
    logic [31:0] wb_mul_result_o, wb_data_rd_data_o;
`ifdef CORE_MEM_BUS_ERR_EN
    logic        data_err = 1'b0;
    logic        bus_err_o;
`endif

    always #5 clk = ~clk;

    core_mem_stage #(.XLEN(32), .FLEN(32)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .ex_valid_i       (ex_valid),
        .mem_read_i       (mem_read),
        .mem_write_i      (mem_write),
        .d_size_i         (d_size),
        .d_unsigned_i     (d_uns),
        .mem_to_reg_i     (m2r),
        .reg_write_i      (reg_write),
        .rd_addr_i        (rd_addr),
        .alu_result_i     (alu),
        .rs2_data_i       (rs2),
        .imm_i            (imm),
        .pc_plus_4_i      (pc4),
        .mul_result_i     (mul),
        .stall_o          (stall_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (gnt),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (rvalid),
        .data_rdata_i     (rdata),
`ifdef CORE_MEM_BUS_ERR_EN
        .data_err_i       (data_err),
        .bus_err_o        (bus_err_o),
`endif
        .misalign_o       (misalign_o),
        .wb_valid_o       (wb_valid_o),
        .wb_d_size_o      (wb_d_size_o),
        .wb_d_unsigned_o  (wb_d_unsigned_o),
        .wb_mem_to_reg_o  (wb_mem_to_reg_o),
        .wb_reg_write_o   (wb_reg_write_o),
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_alu_result_o  (wb_alu_result_o),
        .wb_imm_o         (wb_imm_o),
        .wb_pc_plus_4_o   (wb_pc_plus_4_o),
        .wb_mul_result_o  (wb_mul_result_o),
        .wb_data_rd_data_o(wb_data_rd_data_o)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    pl_t  exp_pl;
    pl_t  last_pl = '0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pl_t dut_pl();
        return pl_t'({wb_d_size_o, wb_d_unsigned_o, wb_mem_to_reg_o,
                      wb_reg_write_o, wb_rd_addr_o, wb_alu_result_o,
                      wb_imm_o, wb_pc_plus_4_o, wb_mul_result_o});
    endfunction

    // Reference: access width in bytes, enables and replicated lanes.
    function automatic void ref_align(input logic [3:0] sz,
                                      input logic [31:0] addr,
                                      input logic [31:0] data,
                                      output logic [3:0] be,
                                      output logic [31:0] wd,
                                      output bit mis);
        int n;
        int off;
        n   = (sz == 4'b0001) ? 1 : (sz == 4'b0011) ? 2 : 4;
        mis = (addr % n) != 0;
        off = (n == 4) ? 0 : int'(addr % 4);
        be  = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) be[off+i] = 1'b1;
        for (int b = 0; b < 4; b++)
            wd[8*b +: 8] = data[8*(b % n) +: 8];
    endfunction

    task automatic drive_op(input logic rd_op, input logic wr_op,
                            input logic [3:0] sz, input logic [31:0] addr,
                            input logic [31:0] data, input logic rw);
        ex_valid  = 1'b1;
        mem_read  = rd_op;
        mem_write = wr_op;
        d_size    = sz;
        d_uns     = 1'($urandom);
        m2r       = 3'($urandom);
        reg_write = rw;
        rd_addr   = 5'($urandom);
        alu       = addr;
        rs2       = data;
        imm       = $urandom;
        pc4       = $urandom;
        mul       = $urandom;
        exp_pl    = {sz, d_uns, m2r, rw, rd_addr, addr, imm, pc4, mul};
    endtask

    task automatic ex_clear();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_bus"}, {data_req_o, data_we_o, data_be_o, data_addr_o,
            data_wdata_o, stall_o, misalign_o, wb_valid_o}, '0);
        chk({nm, "_wb"}, {dut_pl(), wb_data_rd_data_o}, '0);
`ifdef CORE_MEM_BUS_ERR_EN
        chk({nm, "_buserr"}, bus_err_o, 0);
`endif
    endtask

    vec_t vt[10];

    initial begin
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr;
        bit          emis;
        int          nreq;
        int          kind, gd, rdl;
        logic [3:0]  sz;
        logic [3:0]  sizes[4];

        vt[0] = '{4'b0001, 2'd0, 4'b0001, 32'h44444444, 1'b0};
        vt[1] = '{4'b0001, 2'd1, 4'b0010, 32'h44444444, 1'b0};
        vt[2] = '{4'b0001, 2'd3, 4'b1000, 32'h44444444, 1'b0};
        vt[3] = '{4'b0011, 2'd0, 4'b0011, 32'h33443344, 1'b0};
        vt[4] = '{4'b0011, 2'd2, 4'b1100, 32'h33443344, 1'b0};
        vt[5] = '{4'b0011, 2'd1, 4'b0000, 32'h00000000, 1'b1};
        vt[6] = '{4'b1111, 2'd0, 4'b1111, 32'h11223344, 1'b0};
        vt[7] = '{4'b1111, 2'd2, 4'b0000, 32'h00000000, 1'b1};
        vt[8] = '{4'b0000, 2'd0, 4'b1111, 32'h11223344, 1'b0};
        vt[9] = '{4'b0111, 2'd1, 4'b0000, 32'h00000000, 1'b1};

        #3;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // ALU op: latency one, never stalls
        drive_op(1'b0, 1'b0, 4'b1111, 32'h1234, 32'h0, 1'b1);
        chk("alu_stall_pre", stall_o, 0);
        tick();
        ex_clear();
        chk("alu_wb_valid", wb_valid_o, 1);
        chk("alu_result", wb_alu_result_o, 32'h1234);
        chk("alu_stall", stall_o, 0);
        chk("alu_payload", dut_pl(), exp_pl);
        tick();
        chk("alu_wb_drop", wb_valid_o, 0);

        // Store byte with grant delayed two cycles
        drive_op(1'b0, 1'b1, 4'b0001, 32'h1003, 32'hAB, 1'b0);
        tick();
        ex_clear();
        chk("sb_be", data_be_o, 4'b1000);
        chk("sb_wdata", data_wdata_o, 32'hABABABAB);
        chk("sb_addr", data_addr_o, 32'h1000);
        chk("sb_we", data_we_o, 1);
        nreq = 0;
        for (int c = 0; c < 3; c++) begin
            if (data_req_o && data_addr_o == 32'h1000) nreq++;
            if (c == 2) gnt = 1'b1;
            tick();
        end
        gnt = 1'b0;
        chk("sb_req_cycles", nreq, 3);
        chk("sb_req_drop", data_req_o, 0);
        chk("sb_wait_stall", stall_o, 1);
        chk("sb_wait_wbv", wb_valid_o, 0);
        rvalid = 1'b1;
        rdata  = 32'h0;
        tick();
        rvalid = 1'b0;
        chk("sb_wb_valid", wb_valid_o, 1);
        chk("sb_stall_clr", stall_o, 0);
        tick();
        chk("sb_wb_pulse", wb_valid_o, 0);

        // Load word with grant and response together
        drive_op(1'b1, 1'b0, 4'b1111, 32'h2000, 32'h0, 1'b1);
        tick();
        ex_clear();
        chk("lw_req", data_req_o, 1);
        chk("lw_we", data_we_o, 0);
        gnt = 1'b1;
        rvalid = 1'b1;
        rdata = 32'hDEADBEEF;
        tick();
        gnt = 1'b0;
        rvalid = 1'b0;
        chk("lw_rdata", wb_data_rd_data_o, 32'hDEADBEEF);
        chk("lw_wb_valid", wb_valid_o, 1);
        chk("lw_stall", stall_o, 0);
        chk("lw_payload", dut_pl(), exp_pl);

        // Misaligned half load
        drive_op(1'b1, 1'b0, 4'b0011, 32'h2001, 32'h0, 1'b1);
        tick();
        ex_clear();
        chk("lh_mis", misalign_o, 1);
        chk("lh_req", data_req_o, 0);
        chk("lh_wb_valid", wb_valid_o, 1);
        chk("lh_reg_write", wb_reg_write_o, 0);
        chk("lh_stall", stall_o, 0);
        tick();
        chk("lh_mis_pulse", misalign_o, 0);

        // Reset while waiting for a response
        drive_op(1'b1, 1'b0, 4'b1111, 32'h3000, 32'h0, 1'b1);
        tick();
        ex_clear();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("rst_wait_stall", stall_o, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        rvalid = 1'b1;
        rdata = 32'h5555AAAA;
        tick();
        chk("rst_ign_wbv0", wb_valid_o, 0);
        tick();
        rvalid = 1'b0;
        chk("rst_ign_wbv1", wb_valid_o, 0);
        chk("rst_ign_rdata", wb_data_rd_data_o, 0);
        chk("rst_ign_stall", stall_o, 0);

`ifdef CORE_MEM_BUS_ERR_EN
        drive_op(1'b1, 1'b0, 4'b1111, 32'h4000, 32'h0, 1'b1);
        tick();
        ex_clear();
        gnt = 1'b1;
        rvalid = 1'b1;
        data_err = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b0;
        data_err = 1'b0;
        chk("berr_pulse", bus_err_o, 1);
        chk("berr_wbv", wb_valid_o, 1);
        chk("berr_rw", wb_reg_write_o, 0);
        tick();
        chk("berr_drop", bus_err_o, 0);
`endif

        // Vector table: alignment, enables and replication per size
        for (int i = 0; i < 10; i++) begin
            drive_op(1'b0, 1'b1, vt[i].sz, 32'h4000 | 32'(vt[i].a),
                     32'h11223344, 1'b0);
            tick();
            ex_clear();
            chk($sformatf("vec%0d_mis", i), misalign_o, vt[i].mis);
            chk($sformatf("vec%0d_req", i), data_req_o, !vt[i].mis);
            if (vt[i].mis) begin
                chk($sformatf("vec%0d_wbv", i), wb_valid_o, 1);
            end else begin
                chk($sformatf("vec%0d_be", i), data_be_o, vt[i].be);
                chk($sformatf("vec%0d_wd", i), data_wdata_o, vt[i].wd);
                gnt = 1'b1;
                rvalid = 1'b1;
                tick();
                gnt = 1'b0;
                rvalid = 1'b0;
                chk($sformatf("vec%0d_done", i), wb_valid_o, 1);
            end
        end

        // Randomized transactions against the reference model
        sizes = '{4'b0001, 4'b0011, 4'b1111, 4'b0000};
        last_pl = dut_pl();
        last_rd = wb_data_rd_data_o;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 2);
            sz = sizes[$urandom_range(0, 3)];
            if (sz == 4'b0000) sz = 4'($urandom);
            eaddr = $urandom;
            drive_op(kind == 1, kind == 2, sz, eaddr, $urandom,
                     (kind == 2) ? 1'b0 : 1'($urandom));
            ref_align(sz, eaddr, rs2, ebe, ewd, emis);
            chk("rnd_idle", stall_o, 0);
            tick();
            ex_clear();
            if (kind == 0 || emis) begin
                if (kind != 0) exp_pl.rw = 1'b0;
                chk("rnd_imm_wbv", wb_valid_o, 1);
                chk("rnd_imm_mis", misalign_o, kind != 0);
                chk("rnd_imm_req", data_req_o, 0);
                chk("rnd_imm_pl", dut_pl(), exp_pl);
                chk("rnd_imm_rd", wb_data_rd_data_o, last_rd);
            end else begin
                chk("rnd_req", data_req_o, 1);
                chk("rnd_we", data_we_o, kind == 2);
                chk("rnd_be", data_be_o, ebe);
                chk("rnd_wd", data_wdata_o, ewd);
                chk("rnd_addr", data_addr_o, eaddr & 32'hFFFFFFFC);
                chk("rnd_stall", stall_o, 1);
                chk("rnd_hold_pl", dut_pl(), last_pl);
                gd = $urandom_range(0, 3);
                rdl = $urandom_range(0, 3);
                for (int c = 0; c < gd; c++) begin
                    tick();
                    chk("rnd_req_hold", {data_req_o, data_addr_o},
                        {1'b1, eaddr & 32'hFFFFFFFC});
                end
                gnt = 1'b1;
                rvalid = (rdl == 0);
                rdata = $urandom;
                tick();
                gnt = 1'b0;
                if (rdl > 0) begin
                    chk("rnd_gnt_req", data_req_o, 0);
                    rvalid = 1'b0;
                    for (int c = 1; c < rdl; c++) begin
                        tick();
                        chk("rnd_wait_wbv", wb_valid_o, 0);
                        chk("rnd_wait_stall", stall_o, 1);
                    end
                    rvalid = 1'b1;
                    rdata = $urandom;
                    tick();
                end
                rvalid = 1'b0;
                chk("rnd_wbv", wb_valid_o, 1);
                chk("rnd_pl", dut_pl(), exp_pl);
                chk("rnd_rd", wb_data_rd_data_o, rdata);
                chk("rnd_done_stall", stall_o, 0);
                last_rd = rdata;
            end
            last_pl = exp_pl;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                mem_read = 1'($urandom);
                rvalid = 1'($urandom);
                rdata = $urandom;
                tick();
                chk("rnd_gap_wbv", wb_valid_o, 0);
                chk("rnd_gap_pl", {dut_pl(), wb_data_rd_data_o},
                    {last_pl, last_rd});
            end
            rvalid = 1'b0;
            mem_read = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
